dp_detect_scheduler: RTL and testbench
======================================

# dp_detect_scheduler

Result arbiter and sequencer for a bank of N parallel DP matching engines, one per keyword template. It captures each engine's score/length on its data-valid and scans the captured results one engine per cycle through a single shared threshold multiplier. It reports the best passing template, then holds all engines in reset for a flush window. It also generates the VAD hangover signal consumed downstream.

## Interface
- BIT, 32: feature width; engine score is BIT+13 bits, threshold BIT+6 bits
- N, 4: number of engines/templates (2..16)
- FLUSH_CYC, 2: cycles eng_reset is held after a detection (≥1)
- HANG_CYC, 3000000: VAD hangover length in clk cycles (< 2^22)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- eng_dv  in  N  per-engine result valid, bit k = engine k
- eng_scr  in  N*(BIT+13)  packed scores, engine k at [k*(BIT+13) +: BIT+13]
- eng_len  in  N*7  packed path lengths, engine k at [k*7 +: 7]
- thr  in  BIT+6  per-frame score threshold
- vad_in  in  1  raw voice-activity flag
- eng_reset  out  1  reset to all DP engines (ORed with reset externally)
- det_dv  out  1  one-cycle detection strobe
- det_id  out  4  winning engine index
- det_scr  out  BIT+13  winning score
- det_len  out  7  winning length
- vad_out  out  1  VAD with hangover

## Operation
- Capture: on any edge with eng_dv[k]=1 (and state ≠ FLUSH), cap_scr[k]/cap_len[k] load from the input and pend[k] sets.
- States: IDLE, SCAN, REPORT, FLUSH.
- IDLE: if any pend bit is set, latch thr into thr_q, clear best, idx=0 → SCAN.
- SCAN: each cycle evaluate engine idx. If pend[idx]=1: clear pend[idx]; entry valid when cap_scr ≠ all-ones and cap_len ≠ 0; passes when cap_scr < cap_len*thr_q (unsigned, product computed at BIT+13 bits, no truncation). A passing entry replaces best when no best exists or cap_scr < best_scr; on ties the lower index is kept. idx=N-1 → REPORT if best exists, else IDLE.
- REPORT: det_dv=1 for one cycle; det_id/scr/len load from best and hold until the next detection. eng_reset=1. → FLUSH.
- FLUSH: eng_reset stays high for FLUSH_CYC cycles in total, counted from REPORT; pend cleared; eng_dv ignored. → IDLE.
- Simultaneous capture and evaluation of the same k: evaluation uses the old captured value; the new value loads and pend[k] stays set, so it is evaluated in the next scan.
- VAD: while vad_out=0, vad_in=1 sets it on the next edge. While vad_out=1, vad_in=1 clears the 22-bit counter. vad_in=0 increments the counter; when counter==HANG_CYC, vad_out clears and the counter clears.

## Timing
- Reset values: eng_reset=0, det_dv=0, det_id=0, det_scr=0, det_len=0, vad_out=0; state IDLE, pend=0, counter=0.
- eng_dv captured at edge E0 → SCAN entered at E0+1 → engine k evaluated at edge E0+2+k → det_dv high in the cycle after edge E0+N+2 → eng_reset high for FLUSH_CYC cycles starting with the det_dv cycle.
- Worst-case report latency is N+2 cycles from capture. No back-pressure; eng_dv may pulse every cycle.
- Reset asserted mid-SCAN or mid-FLUSH: immediate return to reset values; no det_dv is issued.

## Configuration
- DP_DETECT_VAD_GATE_EN defined: REPORT only occurs if vad_out=1 at the transition out of SCAN; otherwise best is discarded → IDLE, with no strobe and no flush.
- Undefined: detections are reported regardless of vad_out.

## Test plan
- N=4, thr=10, engine 2 dv with scr=50, len=6 (50<60) → det_dv one cycle at E0+N+2, det_id=2, det_scr=50, det_len=6; eng_reset high 2 cycles.
- Engines 1 and 3 dv on the same edge with scr=40, len=5 and scr=30, len=5 (thr=10) → det_id=3, det_scr=30; a tie at scr=30 on both → det_id=1.
- scr=all-ones or len=0 with an otherwise passing thr → no det_dv, state returns to IDLE, pend=0.
- eng_dv[0] pulses in the same cycle engine 0 is evaluated → the old value is judged; the new value produces a second scan.
- With HANG_CYC=5: vad_in 1 for 1 cycle then 0 → vad_out high, falling exactly 5 edges after the counter starts; with DP_DETECT_VAD_GATE_EN and vad_out=0, a passing result → no det_dv.
- reset asserted during FLUSH → eng_reset drops immediately, all outputs 0.

Source files
------------

// File: rtl/dp_detect_scheduler_if.sv
// Bundle between the DP engine bank and the detection scheduler.
// Latency: pure wiring, no storage.
// Backpressure: none; engines may present results every cycle.
interface dp_detect_scheduler_if #(
    parameter int BIT = 32,
    parameter int N   = 4
);
    localparam int SW = BIT + 13;
    localparam int TW = BIT + 6;

    logic [N-1:0]    eng_dv;
    logic [N*SW-1:0] eng_scr;
    logic [N*7-1:0]  eng_len;
    logic [TW-1:0]   thr;
    logic            vad_in;
    logic            eng_reset;
    logic            det_dv;
    logic [3:0]      det_id;
    logic [SW-1:0]   det_scr;
    logic [6:0]      det_len;
    logic            vad_out;

    // Engine bank / frame control side.
    modport master (
        output eng_dv, eng_scr, eng_len, thr, vad_in,
        input  eng_reset, det_dv, det_id, det_scr, det_len, vad_out
    );

    // Scheduler side.
    modport slave (
        input  eng_dv, eng_scr, eng_len, thr, vad_in,
        output eng_reset, det_dv, det_id, det_scr, det_len, vad_out
    );
endinterface

// File: rtl/dp_detect_scheduler.sv
// Captures N DP engine results, scans them through one shared threshold multiplier, reports the best pass, then flushes the engines; also VAD hangover.
// Latency: N+2 cycles from capture edge to the registered det_dv cycle; eng_reset held FLUSH_CYC cycles from det_dv.
// Backpressure: none; eng_dv may pulse every cycle and is ignored only during FLUSH. Optional macro DP_DETECT_VAD_GATE_EN gates reports on vad_out.
module dp_detect_scheduler #(
    parameter int BIT       = 32,
    parameter int N         = 4,
    parameter int FLUSH_CYC = 2,
    parameter int HANG_CYC  = 3000000
) (
    input logic                  clk,
    input logic                  reset,
    dp_detect_scheduler_if.slave bus
);
    localparam int SW = BIT + 13;
    localparam int TW = BIT + 6;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [FW-1:0] FLUSH_END = FW'(FLUSH_CYC - 1);
    localparam logic [21:0]   HANG_END  = 22'(HANG_CYC);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT, FLUSH} state_t;

    state_t        state;
    logic [SW-1:0] cap_scr [N];
    logic [6:0]    cap_len [N];
    logic [N-1:0]  pend;
    logic [TW-1:0] thr_q;
    logic [IW-1:0] idx;
    logic          best_vld;
    logic [IW-1:0] best_id;
    logic [SW-1:0] best_scr;
    logic [6:0]    best_len;
    logic [FW-1:0] fcnt;
    logic [21:0]   vad_cnt;
    logic          vad_q;

    logic          eng_reset_q;
    logic          det_dv_q;
    logic [3:0]    det_id_q;
    logic [SW-1:0] det_scr_q;
    logic [6:0]    det_len_q;

    logic [SW-1:0] ev_scr;
    logic [6:0]    ev_len;
    logic [SW-1:0] ev_prod;
    logic          ev_pass;
    logic          ev_take;
    logic [N-1:0]  pend_clr;
    logic [N-1:0]  pend_set;

    assign bus.eng_reset = eng_reset_q;
    assign bus.det_dv    = det_dv_q;
    assign bus.det_id    = det_id_q;
    assign bus.det_scr   = det_scr_q;
    assign bus.det_len   = det_len_q;
    assign bus.vad_out   = vad_q;

    // Judge the engine under the scan pointer; len (7b) x thr (BIT+6b) fits SW bits exactly.
    always_comb begin
        ev_scr  = cap_scr[idx];
        ev_len  = cap_len[idx];
        ev_prod = SW'(ev_len) * SW'(thr_q);
        ev_pass = (state == SCAN) && pend[idx] && (ev_scr != '1) &&
                  (ev_len != 7'd0) && (ev_scr < ev_prod);
        // Strict compare: on equal scores the earlier (lower) index stays best.
        ev_take = ev_pass && (!best_vld || (ev_scr < best_scr));
    end

    // Pending-bit masks: a capture on the same edge as its evaluation wins, so it is rescanned.
    always_comb begin
        pend_clr = '0;
        if (state == SCAN) begin
            pend_clr[idx] = 1'b1;
        end
        pend_set = (state == FLUSH) ? '0 : bus.eng_dv;
    end

    // Result capture and pending tracking; the engines are in reset during FLUSH so their outputs are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                cap_scr[k] <= '0;
                cap_len[k] <= '0;
            end
            pend <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (bus.eng_dv[k] && (state != FLUSH)) begin
                    cap_scr[k] <= bus.eng_scr[k*SW +: SW];
                    cap_len[k] <= bus.eng_len[k*7 +: 7];
                end
            end
            if (state == FLUSH) begin
                pend <= '0;
            end else begin
                pend <= (pend & ~pend_clr) | pend_set;
            end
        end
    end

    // Scan / report / flush sequencer with registered detection and engine-reset outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            thr_q       <= '0;
            idx         <= '0;
            best_vld    <= 1'b0;
            best_id     <= '0;
            best_scr    <= '0;
            best_len    <= '0;
            fcnt        <= '0;
            eng_reset_q <= 1'b0;
            det_dv_q    <= 1'b0;
            det_id_q    <= '0;
            det_scr_q   <= '0;
            det_len_q   <= '0;
        end else begin
            det_dv_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pend) begin
                        thr_q    <= bus.thr;
                        best_vld <= 1'b0;
                        idx      <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (ev_take) begin
                        best_vld <= 1'b1;
                        best_id  <= idx;
                        best_scr <= ev_scr;
                        best_len <= ev_len;
                    end
                    if (idx == LAST_IDX) begin
`ifdef DP_DETECT_VAD_GATE_EN
                        state <= ((best_vld || ev_take) && vad_q) ? REPORT : IDLE;
`else
                        state <= (best_vld || ev_take) ? REPORT : IDLE;
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                REPORT: begin
                    det_dv_q    <= 1'b1;
                    det_id_q    <= 4'(best_id);
                    det_scr_q   <= best_scr;
                    det_len_q   <= best_len;
                    eng_reset_q <= 1'b1;
                    fcnt        <= '0;
                    state       <= FLUSH;
                end
                FLUSH: begin
                    if (fcnt == FLUSH_END) begin
                        eng_reset_q <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // VAD hangover: set on activity, hold until HANG_CYC quiet cycles have been counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vad_q   <= 1'b0;
            vad_cnt <= '0;
        end else if (!vad_q) begin
            if (bus.vad_in) begin
                vad_q <= 1'b1;
            end
        end else if (bus.vad_in) begin
            vad_cnt <= '0;
        end else if (vad_cnt == HANG_END) begin
            vad_q   <= 1'b0;
            vad_cnt <= '0;
        end else begin
            vad_cnt <= vad_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dp_detect_scheduler.sv
// Directed bench for dp_detect_scheduler with N=4, FLUSH_CYC=2, HANG_CYC=5.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: none exercised; the scheduler has none.
module tb_dp_detect_scheduler;
    localparam int BIT       = 32;
    localparam int N         = 4;
    localparam int FLUSH_CYC = 2;
    localparam int HANG_CYC  = 5;
    localparam int SW        = BIT + 13;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic seen;

    dp_detect_scheduler_if #(.BIT(BIT), .N(N)) bus ();

    dp_detect_scheduler #(
        .BIT(BIT), .N(N), .FLUSH_CYC(FLUSH_CYC), .HANG_CYC(HANG_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_eng(input int k, input logic [SW-1:0] scr, input logic [6:0] len);
        bus.eng_scr[k*SW +: SW] = scr;
        bus.eng_len[k*7 +: 7]   = len;
    endtask

    // Pulse eng_dv for one edge (E0) with the given mask.
    task automatic pulse(input logic [N-1:0] mask);
        bus.eng_dv = mask;
        tick();
        bus.eng_dv = '0;
    endtask

    initial begin
        logic [SW-1:0] all_ones;
        all_ones = '1;
        checks   = 0;
        failures = 0;
        reset          = 1'b1;
        bus.eng_dv     = '0;
        bus.eng_scr    = '0;
        bus.eng_len    = '0;
        bus.thr        = '0;
        bus.vad_in     = 1'b0;

        #12;
        check("rst_eng_reset", 64'(bus.eng_reset), 64'd0);
        check("rst_det_dv",    64'(bus.det_dv),    64'd0);
        check("rst_det_id",    64'(bus.det_id),    64'd0);
        check("rst_det_scr",   64'(bus.det_scr),   64'd0);
        check("rst_det_len",   64'(bus.det_len),   64'd0);
        check("rst_vad_out",   64'(bus.vad_out),   64'd0);
        reset = 1'b0;

        // Keep voice active so gated builds still report in the early tests.
        bus.vad_in = 1'b1;
        bus.thr    = 10;
        tick();
        check("vad_set", 64'(bus.vad_out), 64'd1);

        // Single engine 2: 50 < 6*10.
        set_eng(2, 50, 6);
        pulse(4'b0100);
        repeat (5) tick();
        check("t1_not_early", 64'(bus.det_dv), 64'd0);
        tick();
        check("t1_det_dv",    64'(bus.det_dv),    64'd1);
        check("t1_det_id",    64'(bus.det_id),    64'd2);
        check("t1_det_scr",   64'(bus.det_scr),   64'd50);
        check("t1_det_len",   64'(bus.det_len),   64'd6);
        check("t1_eng_reset", 64'(bus.eng_reset), 64'd1);
        tick();
        check("t1_dv_drop",   64'(bus.det_dv),    64'd0);
        check("t1_flush2",    64'(bus.eng_reset), 64'd1);
        check("t1_id_hold",   64'(bus.det_id),    64'd2);
        tick();
        check("t1_flush_end", 64'(bus.eng_reset), 64'd0);

        // Engines 1 and 3 both pass; lower score wins.
        set_eng(1, 40, 5);
        set_eng(3, 30, 5);
        pulse(4'b1010);
        repeat (6) tick();
        check("t2_det_dv",  64'(bus.det_dv),  64'd1);
        check("t2_det_id",  64'(bus.det_id),  64'd3);
        check("t2_det_scr", 64'(bus.det_scr), 64'd30);
        check("t2_det_len", 64'(bus.det_len), 64'd5);
        repeat (2) tick();

        // Tie at 30: lower index kept.
        set_eng(1, 30, 5);
        set_eng(3, 30, 5);
        pulse(4'b1010);
        repeat (6) tick();
        check("t2_tie_dv",  64'(bus.det_dv),  64'd1);
        check("t2_tie_id",  64'(bus.det_id),  64'd1);
        check("t2_tie_scr", 64'(bus.det_scr), 64'd30);
        repeat (2) tick();

        // Invalid entries: all-ones score on engine 0, zero length on engine 1.
        bus.thr = '1;
        set_eng(0, all_ones, 7'd127);
        set_eng(1, 5, 0);
        pulse(4'b0011);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (bus.det_dv) seen = 1'b1;
        end
        check("t3_no_det",    64'(seen),          64'd0);
        check("t3_pend_zero", 64'(dut.pend),      64'd0);
        check("t3_no_flush",  64'(bus.eng_reset), 64'd0);
        bus.thr = 10;

        // Capture collides with evaluation of engine 0: old 60 fails, new 20 passes in a second scan.
        set_eng(0, 60, 5);
        pulse(4'b0001);
        tick();
        set_eng(0, 20, 5);
        pulse(4'b0001);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (bus.det_dv) seen = 1'b1;
        end
        check("t4_first_scan_quiet", 64'(seen), 64'd0);
        tick();
        check("t4_det_dv",  64'(bus.det_dv),  64'd1);
        check("t4_det_id",  64'(bus.det_id),  64'd0);
        check("t4_det_scr", 64'(bus.det_scr), 64'd20);
        repeat (2) tick();

        // VAD hangover: counter starts on the first quiet edge, output falls on the 6th.
        bus.vad_in = 1'b0;
        repeat (5) tick();
        check("t5_vad_hold", 64'(bus.vad_out), 64'd1);
        tick();
        check("t5_vad_fall", 64'(bus.vad_out), 64'd0);
        tick();
        check("t5_vad_stay", 64'(bus.vad_out), 64'd0);

        // Passing result with vad_out low.
        set_eng(2, 50, 6);
        pulse(4'b0100);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (bus.det_dv) seen = 1'b1;
        end
`ifdef DP_DETECT_VAD_GATE_EN
        check("t6_gated_no_det", 64'(seen),          64'd0);
        check("t6_gated_no_rst", 64'(bus.eng_reset), 64'd0);
`else
        check("t6_ungated_det",  64'(seen),          64'd1);
`endif

        // Reset in the middle of FLUSH.
        bus.vad_in = 1'b1;
        tick();
        set_eng(2, 50, 6);
        pulse(4'b0100);
        repeat (6) tick();
        check("t7_pre_dv", 64'(bus.det_dv),    64'd1);
        check("t7_pre_er", 64'(bus.eng_reset), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t7_eng_reset", 64'(bus.eng_reset), 64'd0);
        check("t7_det_dv",    64'(bus.det_dv),    64'd0);
        check("t7_det_id",    64'(bus.det_id),    64'd0);
        check("t7_det_scr",   64'(bus.det_scr),   64'd0);
        check("t7_det_len",   64'(bus.det_len),   64'd0);
        check("t7_vad_out",   64'(bus.vad_out),   64'd0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (bus.det_dv || bus.eng_reset) seen = 1'b1;
        end
        check("t7_quiet_after", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
